// File: rtl/pc_fetch_unit_if.sv
// Bundle between the fetch unit and its environment: branch redirect, hazard
// control, instruction memory port and the IF/ID pipeline register outputs.
interface pc_fetch_unit_if #(
  parameter int PC_W  = 9,
  parameter int INS_W = 32
);
  logic             PcSel;
  logic [31:0]      BrPC;
  logic             halt;
  logic             Stall;
  logic [INS_W-1:0] Imem_Rdata;
  logic [PC_W-1:0]  Imem_Addr;
  logic             Imem_Req;
  logic [PC_W-1:0]  Cur_PC;
  logic [PC_W-1:0]  IfId_PC;
  logic [INS_W-1:0] IfId_Instr;
  logic             IfId_Valid;
  logic             Halted;
  logic             Misalign;

  modport master (
    input  PcSel, BrPC, halt, Stall, Imem_Rdata,
    output Imem_Addr, Imem_Req, Cur_PC, IfId_PC, IfId_Instr, IfId_Valid, Halted, Misalign
  );

  modport slave (
    output PcSel, BrPC, halt, Stall, Imem_Rdata,
    input  Imem_Addr, Imem_Req, Cur_PC, IfId_PC, IfId_Instr, IfId_Valid, Halted, Misalign
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// PC register and IF stage: next-PC selection, IF/ID register with flush/stall, halt FSM.
// Optional feature macro FETCH_MISALIGN_TRAP_EN: misaligned redirect traps into HALTED.
module pc_fetch_unit #(
  parameter int                PC_W     = 9,
  parameter int                INS_W    = 32,
  parameter logic [PC_W-1:0]   RESET_PC = '0,
  parameter logic [INS_W-1:0]  NOP_INS  = 32'h00000013
) (
  input  logic            clk,
  input  logic            reset,
  pc_fetch_unit_if.master bus
);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [PC_W-1:0]  ifPc_q, ifPc_d;
  logic [INS_W-1:0] ifInstr_q, ifInstr_d;
  logic             ifValid_q, ifValid_d;
  logic [PC_W-1:0]  target;
  logic             misTrap;
  logic             unusedBrBits;

  // Redirect targets are always word aligned; bits above PC_W are dropped.
  assign target       = {bus.BrPC[PC_W-1:2], 2'b00};
  assign unusedBrBits = ^{bus.BrPC[31:PC_W], bus.BrPC[1:0]};

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign_q;

  assign misTrap = bus.PcSel && (bus.BrPC[1:0] != 2'b00);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      misalign_q <= 1'b0;
    end else if (misTrap && (state_q == RUN)) begin
      misalign_q <= 1'b1;
    end
  end

  assign bus.Misalign = misalign_q;
`else
  assign misTrap      = 1'b0;
  assign bus.Misalign = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RUN;
      pc_q      <= RESET_PC;
      ifPc_q    <= '0;
      ifInstr_q <= NOP_INS;
      ifValid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ifPc_q    <= ifPc_d;
      ifInstr_q <= ifInstr_d;
      ifValid_q <= ifValid_d;
    end
  end

  // Halted or redirecting flushes IF/ID; a stall freezes PC and IF/ID together.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ifPc_d    = ifPc_q;
    ifInstr_d = ifInstr_q;
    ifValid_d = ifValid_q;

    if (state_q == HALTED) begin
      ifValid_d = 1'b0;
      ifInstr_d = NOP_INS;
      ifPc_d    = '0;
    end else begin
      if (bus.halt || misTrap) begin
        state_d = HALTED;
      end
      if (bus.PcSel) begin
        ifValid_d = 1'b0;
        ifInstr_d = NOP_INS;
        ifPc_d    = '0;
        if (!misTrap) begin
          pc_d = target;
        end
      end else if (!bus.Stall) begin
        ifValid_d = 1'b1;
        ifInstr_d = bus.Imem_Rdata;
        ifPc_d    = pc_q;
        pc_d      = pc_q + PC_W'(4);
      end
    end
  end

  assign bus.Imem_Addr  = pc_q;
  assign bus.Imem_Req   = (state_q == RUN) && !bus.Stall;
  assign bus.Cur_PC     = pc_q;
  assign bus.IfId_PC    = ifPc_q;
  assign bus.IfId_Instr = ifInstr_q;
  assign bus.IfId_Valid = ifValid_q;
  assign bus.Halted     = (state_q == HALTED);

endmodule
